// File: rtl/pc_select_reg.sv
// pc_select_reg
//   Program counter register with next-PC source selection. Each cycle the PC
//   either advances by STEP, takes a decoded redirect target, or holds on stall.
//   A redirect that arrives while stalled is parked in a pending register. The
//   newest parked redirect wins. It is applied when the stall drops.
//
//   Optional feature: define PC_TRAP_EN to enable the trap input. A trap loads
//   TRAP_VECTOR regardless of stall and discards any pending redirect. Without
//   PC_TRAP_EN the trap port exists but is ignored.
//
// Parameters
//   WIDTH         PC / target width in bits
//   STEP          sequential increment
//   RESET_VECTOR  PC value after reset
//   TRAP_VECTOR   PC value on trap (truncated to WIDTH)
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   stall          in   1 = hold the PC
//   control[2:0]   in   [2:1] source select, [0] branch condition
//   jump_target    in   target for select 10
//   branch_target  in   target for select 11, and 01 when control[0]=1
//   trap           in   trap request (used only with PC_TRAP_EN)
//   pc             out  registered program counter
//   pc_next_seq    out  combinational pc + STEP, wrapping
//   redirected     out  one-cycle pulse after a non-sequential PC load
//   pending        out  high while a stalled redirect is parked (HOLD)
module pc_select_reg #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned STEP         = 4,
   parameter int unsigned RESET_VECTOR = 0,
   parameter int unsigned TRAP_VECTOR  = 32'h00000080
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             stall,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] jump_target,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             trap,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_next_seq,
   output logic             redirected,
   output logic             pending
);

   localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic [WIDTH-1:0] pend_reg, pend_next;
   logic             redir_reg, redir_next;

   logic             has_redir;
   logic [WIDTH-1:0] redir_target;

`ifdef PC_TRAP_EN
   localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);
`else
   // The trap input and vector are intentionally unused in this build.
   logic unused_trap;
   assign unused_trap = &{1'b0, trap, TRAP_VECTOR[0]};
`endif

   // Modular add: the carry out of the top bit is simply dropped.
   assign pc_next_seq = pc_reg + STEP_W;

   // Redirect decode. Select 01 is the conditional branch.
   always_comb begin
      has_redir    = 1'b0;
      redir_target = branch_target;
      case (control[2:1])
         2'b01: has_redir = control[0];
         2'b10: begin
            has_redir    = 1'b1;
            redir_target = jump_target;
         end
         2'b11: has_redir = 1'b1;
         default: has_redir = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      pend_next  = pend_reg;
      redir_next = 1'b0;

      case (state_reg)
         RUN: begin
            if (!stall) begin
               pc_next    = has_redir ? redir_target : pc_next_seq;
               redir_next = has_redir;
            end else if (has_redir) begin
               pend_next  = redir_target;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (stall) begin
               if (has_redir)
                  pend_next = redir_target;
            end else begin
               // A redirect decoded on the release cycle is newer than the
               // parked one, so it takes precedence.
               pc_next    = has_redir ? redir_target : pend_reg;
               redir_next = 1'b1;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase

`ifdef PC_TRAP_EN
      if (trap) begin
         pc_next    = TRAP_PC;
         pend_next  = '0;
         redir_next = 1'b1;
         state_next = RUN;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
         pend_reg  <= '0;
         redir_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         pend_reg  <= pend_next;
         redir_reg <= redir_next;
      end
   end

   assign pc         = pc_reg;
   assign redirected = redir_reg;
   assign pending    = (state_reg == HOLD);

endmodule
